// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity
// polarity and the 2-of-3 vote used by the bit sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and result pulses of the UART receiver.
// master drives the line and configuration, slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
);
    logic                   RX_IN;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [PRESC_WIDTH-1:0] Prescale;
    logic [DATA_WIDTH-1:0]  P_DATA;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit captures and the majority
// vote. bit_end marks the last oversampling clock of the current bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic                   start,
    input  logic                   run,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   sampled_bit,
    output logic                   bit_end
);
    localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [PRESC_WIDTH-1:0] half;
    logic [PRESC_WIDTH-1:0] last;
    logic                   s0, s1, s2;
    logic                   third;

    assign half    = prescale >> 1;
    assign last    = prescale - ONE;
    assign bit_end = run && (edge_cnt == last);

    // At Prescale=4 the third capture coincides with bit end, so take it live.
    assign third       = (edge_cnt == half + ONE) ? rx_in : s2;
    assign sampled_bit = maj3(s0, s1, third);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
        end else begin
            if (start)
                edge_cnt <= ONE;
            else if (!run || edge_cnt == last)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + ONE;

            if (edge_cnt == half - ONE) s0 <= rx_in;
            if (edge_cnt == half)       s1 <= rx_in;
            if (edge_cnt == half + ONE) s2 <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialization, optional parity
// and stop check, one-cycle result pulse per completed frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input logic     CLK,
    input logic     RST,
    uart_rx_if.slave bus
);
    localparam int             BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]  BIT_ONE  = BW'(1);

    state_t                 state;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  p_data;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   par_fail;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;
    logic                   sampled_bit;
    logic                   bit_end;
    logic                   start;
    logic                   run;

    assign start = (state == IDLE) && !bus.RX_IN;
    assign run   = (state != IDLE);

    uart_rx_sampler #(.PRESC_WIDTH(PRESC_WIDTH)) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (bus.RX_IN),
        .start       (start),
        .run         (run),
        .prescale    (presc_q),
        .sampled_bit (sampled_bit),
        .bit_end     (bit_end)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            p_data     <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail   <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    // Frame configuration is frozen here for the whole frame.
                    if (!bus.RX_IN) begin
                        state     <= START;
                        presc_q   <= bus.Prescale;
                        par_en_q  <= bus.PAR_EN;
                        par_typ_q <= bus.PAR_TYP;
                        par_fail  <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_end)
                        state <= sampled_bit ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + BIT_ONE;
                        if (bit_cnt == LAST_BIT)
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_fail <= ((^shift_reg) ^ (par_typ_q != PAR_EVEN)) != sampled_bit;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        if (!par_fail && sampled_bit) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_reg;
                        end else begin
                            par_err <= par_fail;
                            stp_err <= !sampled_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.P_DATA     = p_data;
    assign bus.data_valid = data_valid;
    assign bus.par_err    = par_err;
    assign bus.stp_err    = stp_err;

endmodule
